// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that drives the select of a downstream 4:1 mux.
// Optional forced release after HOLD_MAX busy cycles: define MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       timeout
);

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, BUSY} state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sel_d;
  logic [N-1:0]    gnt_d;
  logic            valid_d;
  logic            timeout_d;
  logic            win_found;
  logic [SW-1:0]   win_idx;
  logic [SW-1:0]   scan_idx;
  logic            limit_hit;

`ifdef MUX4_ARB_TIMEOUT_EN
  assign limit_hit = (cnt_q == CW'(HOLD_MAX - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Rotating priority search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned k = 1; k <= N; k++) begin
      scan_idx = ptr_q + SW'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel;
    gnt_d     = gnt;
    valid_d   = valid;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (win_found) begin
          state_d = BUSY;
          gnt_d   = N'(1) << win_idx;
          sel_d   = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        // done wins over a simultaneous forced release, so no timeout pulse then.
        if (done || !req[sel] || limit_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          timeout_d = limit_hit && !done && req[sel];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SW'(3);
      cnt_q   <= '0;
      sel     <= '0;
      gnt     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboarded directed bench for mux4_rr_arbiter; expected outputs are
// queued per cycle by the stimulus and consumed by an independent monitor.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  typedef struct {
    int unsigned cyc;
    logic        v;
    logic [1:0]  s;
    logic        t;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic d, input logic ev,
                      input logic [1:0] es, input logic et);
    exp_t e;
    req  = r;
    done = d;
    e.cyc = cyc + 1;
    e.v = ev; e.s = es; e.t = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] eg;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("stale_expectation", int'(e.cyc), int'(cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e  = sb.pop_front();
      eg = e.v ? (4'b0001 << e.s) : 4'b0000;
      chk("valid", int'(valid), int'(e.v));
      chk("sel", int'(sel), int'(e.s));
      chk("gnt", int'(gnt), int'(eg));
      chk("timeout", int'(timeout), int'(e.t));
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;

    // Idle with no requests.
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

    // All request, done held high (ignored while idle): order 0,1,2,3,0 with gaps.
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b1, 2'(k % 4), 1'b0);
      step(4'b1111, 1'b1, 1'b0, 2'(k % 4), 1'b0);
    end

    // Single requester: grant, hold, done release, regrant after one gap cycle.
    step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    step(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    step(4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Pointer wrap: grant 3, then 0 wins over 3.
    step(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    step(4'b1001, 1'b1, 1'b0, 2'd3, 1'b0);
    step(4'b1001, 1'b0, 1'b1, 2'd0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Owner 2 withdraws; a request from 1 during BUSY is ignored; sel holds 2.
    step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step(4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 2'd2, 1'b0);
    step(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

`ifdef MUX4_ARB_TIMEOUT_EN
    // Forced release after 4 busy cycles, timeout pulse overlaps the gap.
    for (int k = 0; k < 4; k++) step(4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
    step(4'b0110, 1'b0, 1'b0, 2'd1, 1'b1);
    step(4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
    // done coincides with the limit: plain release, no timeout.
    step(4'b0110, 1'b1, 1'b0, 2'd2, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
`else
    // Without forced release a grant is held indefinitely.
    for (int k = 0; k < 8; k++) step(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
`endif

    // Async reset mid-grant: owner 2 (ptr=2), 3 also requesting.
    step(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step(4'b1100, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_valid", int'(valid), 0);
    chk("async_sel", int'(sel), 0);
    step(4'b1100, 1'b0, 1'b0, 2'd0, 1'b0);
    step(4'b1100, 1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(4'b1100, 1'b0, 1'b1, 2'd2, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
